// File: rtl/program_loader.sv
// Byte-stream program loader: parses command frames and writes 32-bit words
// into instruction or data memory, and gates the CPU run enable.
module program_loader #(
   parameter int ADDR_STEP  = 4,
   parameter int IMEM_WORDS = 512,
   parameter int DMEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic [31:0] addr_ext,
   output logic        wen_ext,
   output logic [31:0] wdata_ext,
   output logic        ren_ext,
   output logic [31:0] addr_ext_2,
   output logic        wen_ext_2,
   output logic [31:0] wdata_ext_2,
   output logic        ren_ext_2,
   output logic        enable,
   output logic        busy,
   output logic        err
);

   // state  | meaning
   // IDLE   | waiting for a command byte
   // CNT_HI | expecting word-count high byte
   // CNT_LO | expecting word-count low byte
   // DATA   | collecting the 4 bytes of a word
   // WRITE  | one-cycle memory write strobe, input stalled
   typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DATA, WRITE} state_t;

   localparam logic [31:0] STEP     = 32'(ADDR_STEP);
   localparam logic [31:0] IMEM_LIM = 32'(IMEM_WORDS);
   localparam logic [31:0] DMEM_LIM = 32'(DMEM_WORDS);

   state_t      state, state_nxt;
   logic        accept;
   logic        is_dmem;
   logic [7:0]  cnt_hi;
   logic [15:0] words_left;
   logic [31:0] word_idx;
   logic [31:0] word_addr;
   logic [23:0] shift;
   logic [1:0]  byte_cnt;
   logic        in_range;
   logic [31:0] word_full;

   assign in_ready  = (state != WRITE);
   assign busy      = (state != IDLE);
   assign accept    = in_valid && in_ready;
   assign ren_ext   = 1'b0;
   assign ren_ext_2 = 1'b0;
   assign in_range  = is_dmem ? (word_idx < DMEM_LIM) : (word_idx < IMEM_LIM);
   assign word_full = {shift, in_data};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (accept && (in_data == 8'h01 || in_data == 8'h02)) state_nxt = CNT_HI;
         CNT_HI: if (accept) state_nxt = CNT_LO;
         CNT_LO: if (accept) state_nxt = ({cnt_hi, in_data} == 16'd0) ? IDLE : DATA;
         DATA:   if (accept && byte_cnt == 2'd3) state_nxt = WRITE;
         WRITE:  state_nxt = (words_left == 16'd1) ? IDLE : DATA;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         is_dmem     <= 1'b0;
         cnt_hi      <= '0;
         words_left  <= '0;
         word_idx    <= '0;
         word_addr   <= '0;
         shift       <= '0;
         byte_cnt    <= '0;
         enable      <= 1'b0;
         err         <= 1'b0;
         wen_ext     <= 1'b0;
         wen_ext_2   <= 1'b0;
         addr_ext    <= '0;
         addr_ext_2  <= '0;
         wdata_ext   <= '0;
         wdata_ext_2 <= '0;
      end else begin
         wen_ext   <= 1'b0;
         wen_ext_2 <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  case (in_data)
                     8'h01, 8'h02: begin
                        is_dmem   <= (in_data == 8'h02);
                        enable    <= 1'b0;
                        word_idx  <= '0;
                        word_addr <= '0;
                        byte_cnt  <= '0;
                     end
                     8'h03:   enable <= 1'b1;
                     8'h04:   enable <= 1'b0;
                     default: err    <= 1'b1;
                  endcase
               end
            end
            CNT_HI: if (accept) cnt_hi <= in_data;
            CNT_LO: if (accept) words_left <= {cnt_hi, in_data};
            DATA: begin
               if (accept) begin
                  shift    <= word_full[23:0];
                  byte_cnt <= byte_cnt + 2'd1;
                  // Word complete: present it during the WRITE cycle that follows.
                  if (byte_cnt == 2'd3) begin
                     if (is_dmem) begin
                        addr_ext_2  <= word_addr;
                        wdata_ext_2 <= word_full;
                        wen_ext_2   <= in_range;
                     end else begin
                        addr_ext  <= word_addr;
                        wdata_ext <= word_full;
                        wen_ext   <= in_range;
                     end
                     if (!in_range) err <= 1'b1;
                  end
               end
            end
            WRITE: begin
               words_left <= words_left - 16'd1;
               word_idx   <= word_idx + 32'd1;
               word_addr  <= word_addr + STEP;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR_STEP, default 4, address increment per loaded word.
REQ-002 Parameter IMEM_WORDS, default 512, instruction memory capacity in words.
REQ-003 Parameter DMEM_WORDS, default 1024, data memory capacity in words.
REQ-004 The block SHALL use one clock: clk (input, 1), rising-edge.
REQ-005 The reset SHALL be rst (input, 1), synchronous and active-high.
REQ-006 Ports SHALL be:
- in_valid  in  1  byte stream valid.
- in_data  in  8  byte stream data.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- addr_ext  out  32  imem external address.
- wen_ext  out  1  imem write strobe.
- wdata_ext  out  32  imem write word.
- ren_ext  out  1  constant 0.
- addr_ext_2  out  32  dmem external address.
- wen_ext_2  out  1  dmem write strobe.
- wdata_ext_2  out  32  dmem write word.
- ren_ext_2  out  1  constant 0.
- enable  out  1  CPU run enable.
- busy  out  1  high when state != IDLE.
- err  out  1  sticky error flag.

Function
REQ-007 Frame format SHALL be: command byte; for loads, count_hi and count_lo bytes (16-bit word count), then count words of 4 bytes each, big-endian (first byte = bits 31:24).
REQ-008 Commands SHALL be:
- 0x01 load imem.
- 0x02 load dmem.
- 0x03 set enable=1.
- 0x04 set enable=0.
- any other value: set err, stay IDLE.
REQ-009 FSM states SHALL be IDLE, CNT_HI, CNT_LO, DATA, WRITE.
- IDLE: on 0x01/0x02 go to CNT_HI.
- CNT_HI: go to CNT_LO.
- CNT_LO: go to DATA, or to IDLE if count==0.
- DATA: after the 4th byte go to WRITE.
- WRITE: lasts exactly 1 cycle; go to DATA if words remain, else IDLE.
REQ-010 in_ready SHALL be 1 in IDLE, CNT_HI, CNT_LO and DATA, and 0 in WRITE.
REQ-011 A load command SHALL clear enable in the cycle after it is accepted; enable SHALL remain 0 until a later 0x03 command.
REQ-012 Word address SHALL start at 0 for each load and increment by ADDR_STEP after each WRITE; address arithmetic is 32-bit wrap-around.
REQ-013 In WRITE, exactly one of wen_ext/wen_ext_2 SHALL be 1 for one cycle, chosen by the latched command, with addr/wdata valid in the same cycle.
REQ-014 addr and wdata outputs SHALL hold their last values outside WRITE; wen outputs SHALL be 0 outside WRITE.
REQ-015 Word index >= IMEM_WORDS (imem) or >= DMEM_WORDS (dmem) SHALL suppress wen, set err, and still consume the bytes; the FSM SHALL finish the frame normally.
REQ-016 Commands 0x03/0x04 SHALL update enable in the cycle after acceptance; bytes are accepted only when in_valid && in_ready.
REQ-017 in_valid low in any state SHALL stall the FSM with no state change.
REQ-018 err SHALL be cleared only by rst.
REQ-019 All outputs SHALL be registered except in_ready, busy and the constant ren_ext/ren_ext_2.

Reset
REQ-020 While rst=1 at a clk edge:
- state SHALL become IDLE.
- enable, wen_ext, wen_ext_2 and err SHALL become 0.
- addr_ext, addr_ext_2, wdata_ext, wdata_ext_2 and all counters SHALL become 0.
REQ-021 rst asserted mid-frame SHALL abort the frame, perform no further writes, and leave enable=0.

Verification
REQ-022 Stream 01 00 02 DE AD BE EF 12 34 56 78 -> wen_ext pulses: addr 0 data 0xDEADBEEF, then addr 4 data 0x12345678; wen_ext_2 stays 0; busy falls after the second WRITE.
REQ-023 Stream 02 00 01 00 00 00 2A, then 03 -> wen_ext_2 pulses once at addr_ext_2=0 with data 0x0000002A; enable=1 the cycle after 03 is accepted.
REQ-024 With enable=1, send 01 00 00 -> enable=0 the cycle after 01 is accepted; no write occurs; FSM returns to IDLE.
REQ-025 Send 7F -> err=1, FSM stays IDLE; a following valid 04 frame is still processed and err remains 1.
REQ-026 With IMEM_WORDS=2, load 3 words -> two wen_ext pulses, the third is suppressed, err=1, 12 data bytes consumed.
REQ-027 Assert rst after the 2nd data byte of a load, then replay a full frame -> no write from the aborted frame; the new frame writes starting at address 0.
